// File: rtl/pupil_report_tx_if.sv
// pupil_report_tx_if
//   Point handshake from the gravity/centroid stage to the pupil report
//   transmitter.
//   iPOINT_VALID : one-cycle strobe, coordinates valid in that cycle
//   iPOINT_X     : horizontal centre, unsigned, COORD_WIDTH bits
//   iPOINT_Y     : vertical centre, unsigned, COORD_WIDTH bits
//   master = producer (centroid stage / bench), slave = transmitter.
interface pupil_report_tx_if #(
    parameter int COORD_WIDTH = 11
);
    logic                   iPOINT_VALID;
    logic [COORD_WIDTH-1:0] iPOINT_X;
    logic [COORD_WIDTH-1:0] iPOINT_Y;

    modport master (output iPOINT_VALID, output iPOINT_X, output iPOINT_Y);
    modport slave  (input  iPOINT_VALID, input  iPOINT_X, input  iPOINT_Y);
endinterface

// File: rtl/pupil_report_tx.sv
// pupil_report_tx
//   Serialises pupil-centre points into a fixed 8N1 UART packet:
//   A5, X hi, X lo, Y hi, Y lo [, checksum]. One point may be held pending
//   while a packet is in flight; a further point overwrites it (oDROP).
//   Optional feature macro: PUPIL_REPORT_CHECKSUM_EN appends an XOR checksum
//   of the four coordinate bytes (0xA5 excluded). Undefined: 5-byte packet.
// Ports
//   CLK        : system clock (50 MHz)
//   RST_N      : asynchronous active-low reset
//   iBAUD_X16  : single-cycle enable at 16x baud
//   point_if   : point handshake (slave modport)
//   oTXD       : UART line, registered, idle high
//   oBUSY      : high while a packet is in progress
//   oDROP      : one-cycle pulse when the pending point is overwritten
//   oPKT_CNT   : packets fully sent, wraps at 8 bits
module pupil_report_tx #(
    parameter int COORD_WIDTH = 11,
    parameter int TICK_DIV    = 16
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    iBAUD_X16,
    pupil_report_tx_if.slave        point_if,
    output logic                    oTXD,
    output logic                    oBUSY,
    output logic                    oDROP,
    output logic [7:0]              oPKT_CNT
);
`ifdef PUPIL_REPORT_CHECKSUM_EN
    localparam int NUM_BYTES = 6;
`else
    localparam int NUM_BYTES = 5;
`endif
    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [2:0]     BYTE_LAST = 3'(NUM_BYTES - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_STOP} state_t;

    state_t                 r_state;
    logic [TCW-1:0]         r_tick_cnt;
    logic [2:0]             r_bit_cnt;
    logic [2:0]             r_byte_idx;
    logic [7:0]             r_shift;
    logic [COORD_WIDTH-1:0] r_act_x, r_act_y;
    logic [COORD_WIDTH-1:0] r_pend_x, r_pend_y;
    logic                   r_pend_vld;
    logic                   r_txd, r_busy, r_drop;
    logic [7:0]             r_pkt_cnt;

    // Packet byte for a given point and byte position.
    function automatic logic [7:0] pkt_byte(input logic [COORD_WIDTH-1:0] x,
                                            input logic [COORD_WIDTH-1:0] y,
                                            input logic [2:0] idx);
        logic [15:0] x16;
        logic [15:0] y16;
        logic [7:0]  b;
        x16 = 16'(x);
        y16 = 16'(y);
        case (idx)
            3'd0:    b = 8'hA5;
            3'd1:    b = x16[15:8];
            3'd2:    b = x16[7:0];
            3'd3:    b = y16[15:8];
            3'd4:    b = y16[7:0];
`ifdef PUPIL_REPORT_CHECKSUM_EN
            default: b = x16[15:8] ^ x16[7:0] ^ y16[15:8] ^ y16[7:0];
`else
            default: b = 8'h00;
`endif
        endcase
        return b;
    endfunction

    logic                   w_strobe;
    logic                   w_bit_end;
    logic                   w_pkt_end;
    logic                   w_has_next;
    logic [COORD_WIDTH-1:0] w_next_x, w_next_y;

    assign w_strobe   = point_if.iPOINT_VALID;
    assign w_bit_end  = iBAUD_X16 && (r_tick_cnt == TICK_LAST);
    assign w_pkt_end  = (r_state == S_STOP) && w_bit_end && (r_byte_idx == BYTE_LAST);
    // At packet end the pending point goes first; a strobe arriving in that
    // same cycle is used directly when nothing is pending, so it still
    // follows back-to-back.
    assign w_has_next = r_pend_vld || w_strobe;
    assign w_next_x   = r_pend_vld ? r_pend_x : point_if.iPOINT_X;
    assign w_next_y   = r_pend_vld ? r_pend_y : point_if.iPOINT_Y;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_act_x    <= '0;
            r_act_y    <= '0;
            r_pend_x   <= '0;
            r_pend_y   <= '0;
            r_pend_vld <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
            r_pkt_cnt  <= '0;
        end else begin
            r_drop <= 1'b0;

            // Pending register. While a packet is consumed at its end, the
            // slot is free again, so a simultaneous strobe is not a drop.
            if (w_strobe && r_state != S_IDLE) begin
                if (w_pkt_end) begin
                    if (r_pend_vld) begin
                        r_pend_x <= point_if.iPOINT_X;
                        r_pend_y <= point_if.iPOINT_Y;
                    end
                end else begin
                    r_pend_x   <= point_if.iPOINT_X;
                    r_pend_y   <= point_if.iPOINT_Y;
                    r_pend_vld <= 1'b1;
                    r_drop     <= r_pend_vld;
                end
            end else if (w_pkt_end) begin
                r_pend_vld <= 1'b0;
            end

            if (iBAUD_X16 && (r_state == S_START || r_state == S_DATA || r_state == S_STOP)) begin
                r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    // A tick in the strobe cycle is deliberately ignored.
                    if (w_strobe) begin
                        r_act_x    <= point_if.iPOINT_X;
                        r_act_y    <= point_if.iPOINT_Y;
                        r_byte_idx <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (iBAUD_X16) begin
                        r_tick_cnt <= '0;
                        r_txd      <= 1'b0;
                        r_shift    <= pkt_byte(r_act_x, r_act_y, r_byte_idx);
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_txd     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_byte_idx != BYTE_LAST) begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_shift    <= pkt_byte(r_act_x, r_act_y, r_byte_idx + 1'b1);
                            r_txd      <= 1'b0;
                            r_state    <= S_START;
                        end else begin
                            r_pkt_cnt <= r_pkt_cnt + 1'b1;
                            if (w_has_next) begin
                                r_act_x    <= w_next_x;
                                r_act_y    <= w_next_y;
                                r_byte_idx <= '0;
                                r_shift    <= pkt_byte(w_next_x, w_next_y, 3'd0);
                                r_txd      <= 1'b0;
                                r_state    <= S_START;
                            end else begin
                                r_txd   <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oTXD     = r_txd;
    assign oBUSY    = r_busy;
    assign oDROP    = r_drop;
    assign oPKT_CNT = r_pkt_cnt;
endmodule
